pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch from the instruction memory port.
- Issues one outstanding fetch request at a time and applies stall, branch/jump redirects and trap redirects to select the next PC.
- Discards responses for fetches squashed by a redirect, and presents a valid/ready instruction stream to decode.
- Sits between the decode/execute stages (redirect sources) and the imem interface.

Parameters:
- RESET_VECTOR, 32'h8000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h8000_0004, target used when trap_valid is asserted.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  32  branch/jump target.
- trap_valid  in  1  trap/exception redirect this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, always equals pc_out while imem_req=1.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  fetched instruction.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts instruction (low = stall).
- if_pc  out  32  PC of presented instruction.
- if_instr  out  32  presented instruction.
- pc_out  out  32  current fetch PC.
- misalign_err  out  1  one-cycle pulse: redirect_target[1:0] != 0.

Behaviour:
- Reset (rst=0, asynchronous): pc_out=RESET_VECTOR, state=IDLE, imem_req=0, imem_addr=RESET_VECTOR, if_valid=0, if_pc=0, if_instr=0, misalign_err=0.
- States:
  - IDLE: first cycle after reset release, then go to REQ.
  - REQ: imem_req=1. On imem_gnt go to WAIT.
  - WAIT: on imem_rvalid, capture imem_rdata and pc_out into if_instr/if_pc, set if_valid=1, set pc_out=pc_out+4, go to HOLD.
  - HOLD: if_valid=1. When if_ready=1, the instruction is consumed and the FSM goes to REQ next cycle. With if_ready=0, if_valid, if_pc and if_instr are held stable.
  - DROP: a redirect arrived while WAIT. Wait for imem_rvalid, discard the data, then go to REQ.
- Redirect priority: trap_valid > redirect_valid > sequential.
  - Redirect target is TRAP_VECTOR or {redirect_target[31:2],2'b00}.
  - pc_out is updated on the same edge.
  - A misaligned target pulses misalign_err for one cycle and is still taken, with low bits cleared.
- Redirect per state:
  - IDLE/REQ: pc_out updated. If imem_gnt=1 in the same cycle, the granted (old) fetch is squashed and the FSM goes to DROP; otherwise it stays in REQ with the new address.
  - WAIT, imem_rvalid=0: go to DROP.
  - WAIT, imem_rvalid=1 in the same cycle: discard the data, go to REQ.
  - HOLD: clear if_valid next cycle, go to REQ. An instruction handshaken in that cycle is still consumed.
  - DROP: pc_out updated, stays in DROP.
- Fetch latency:
  - imem_req is asserted 1 cycle after reset release.
  - if_valid rises the cycle after imem_rvalid.
  - Minimum 3 cycles per instruction with zero-wait memory (REQ, WAIT, HOLD).
- PC arithmetic: 32-bit, wraps modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000). No error is flagged on wrap.
- imem_addr is stable while imem_req=1 and imem_gnt=0, unless a redirect occurs.
- Protocol violations are ignored: imem_rvalid outside WAIT/DROP.

Decomposition:
- Shared package:
  - fetch FSM state enum (IDLE, REQ, WAIT, HOLD, DROP).
  - RESET_VECTOR and TRAP_VECTOR defaults.
  - ILEN_BYTES=4 constant.
- Single module. No sub-module is needed; next-PC select stays inline.

Test Plan:
- Reset then zero-wait memory (gnt same cycle as req, rvalid next cycle), if_ready=1 → imem_addr sequence 0x80000000, 0x80000004, 0x80000008; if_pc matches and if_instr equals the returned rdata.
- if_ready=0 for 5 cycles while HOLD with instr 0xCAFEBABE → if_valid, if_pc and if_instr stable; no imem_req until if_ready=1.
- redirect_valid with target 0x80000100 during WAIT, then rvalid with 0xDEADBEEF → data dropped (if_valid stays 0); next imem_addr=0x80000100.
- trap_valid and redirect_valid (0x80000200) in the same cycle → pc_out=0x80000004 (TRAP_VECTOR).
- redirect_target=0x80000102 → misalign_err pulses one cycle; imem_addr=0x80000100.
- rst asserted mid-WAIT → outputs return to reset values immediately; first request after release is at 0x80000000. A separate case with pc_out forced to 0xFFFFFFFC and completing that fetch → next imem_addr=0x00000000.

Source files
------------

// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared state encoding and address constants for the instruction fetch sequencer.
package pc_fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h8000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h8000_0004;
  localparam logic [31:0] ILEN_BYTES           = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner: issues one fetch at a time, squashes in-flight fetches on
// redirects and hands fetched instructions to decode over a valid/ready stream.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] pc_out,
  output logic        misalign_err
);

  fetch_state_t state;

  logic        take_redirect;
  logic [31:0] redirect_pc;
  logic        target_misaligned;

  // Trap wins over branch/jump; a misaligned branch target is flagged but still taken.
  assign take_redirect     = trap_valid | redirect_valid;
  assign redirect_pc       = trap_valid ? TRAP_VECTOR : word_align(redirect_target);
  assign target_misaligned = redirect_valid & ~trap_valid & (redirect_target[1:0] != 2'b00);
  assign imem_addr         = pc_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pc_out       <= RESET_VECTOR;
      imem_req     <= 1'b0;
      if_valid     <= 1'b0;
      if_pc        <= 32'h0;
      if_instr     <= 32'h0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= target_misaligned;
      if (take_redirect) begin
        pc_out <= redirect_pc;
      end

      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end

        REQ: begin
          // A fetch granted alongside a redirect is for the stale PC and must be drained.
          if (imem_gnt) begin
            imem_req <= 1'b0;
            state    <= take_redirect ? DROP : WAIT;
          end
        end

        WAIT: begin
          if (take_redirect) begin
            if (imem_rvalid) begin
              state    <= REQ;
              imem_req <= 1'b1;
            end else begin
              state <= DROP;
            end
          end else if (imem_rvalid) begin
            if_valid <= 1'b1;
            if_pc    <= pc_out;
            if_instr <= imem_rdata;
            pc_out   <= pc_out + ILEN_BYTES;
            state    <= HOLD;
          end
        end

        HOLD: begin
          if (take_redirect || if_ready) begin
            if_valid <= 1'b0;
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end

        DROP: begin
          if (imem_rvalid) begin
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
          if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
`timescale 1ns/1ps
// Bench for pc_fetch_sequencer: directed vector table, reset corner, randomized run vs. model.
module tb_pc_fetch_sequencer;
  import pc_fetch_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] pc_out;
  logic        misalign_err;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pc_fetch_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .pc_out          (pc_out),
    .misalign_err    (misalign_err)
  );

  typedef struct {
    logic        redir;
    logic [31:0] tgt;
    logic        trap;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_if_pc;
    logic [31:0] e_instr;
    logic        e_mis;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic redir, input logic [31:0] tgt, input logic trap,
                              input logic gnt, input logic rvalid, input logic [31:0] rdata,
                              input logic ready, input logic e_req, input logic [31:0] e_pc,
                              input logic e_valid, input logic [31:0] e_if_pc,
                              input logic [31:0] e_instr, input logic e_mis);
    vec_t v;
    v.redir = redir;  v.tgt = tgt;        v.trap = trap;
    v.gnt = gnt;      v.rvalid = rvalid;  v.rdata = rdata;  v.ready = ready;
    v.e_req = e_req;  v.e_pc = e_pc;      v.e_valid = e_valid;
    v.e_if_pc = e_if_pc; v.e_instr = e_instr; v.e_mis = e_mis;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    redirect_valid  = v.redir;
    redirect_target = v.tgt;
    trap_valid      = v.trap;
    imem_gnt        = v.gnt;
    imem_rvalid     = v.rvalid;
    imem_rdata      = v.rdata;
    if_ready        = v.ready;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_req"},      32'(imem_req), 32'd0);
    checkOutput({tag, "_addr"},     imem_addr, DEFAULT_RESET_VECTOR);
    checkOutput({tag, "_pc_out"},   pc_out, DEFAULT_RESET_VECTOR);
    checkOutput({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    checkOutput({tag, "_if_pc"},    if_pc, 32'd0);
    checkOutput({tag, "_if_instr"}, if_instr, 32'd0);
    checkOutput({tag, "_misalign"}, 32'(misalign_err), 32'd0);
  endtask

  task automatic runRandom(input int cycles);
    logic [31:0] exp_pc, exp_if_pc, exp_if_instr, pend_addr, r32, d_tgt;
    logic        exp_valid, exp_mis, exp_req, idle, pend, pend_sq, redir;
    logic        d_redir, d_trap, d_gnt, d_rvalid, d_ready;
    int          delay, delivered;
    d_redir = 0; d_trap = 0; d_gnt = 0; d_rvalid = 0; d_ready = 0; d_tgt = 0;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_pc = DEFAULT_RESET_VECTOR; exp_if_pc = 0; exp_if_instr = 0; pend_addr = 0;
    exp_valid = 0; exp_mis = 0; idle = 1; pend = 0; pend_sq = 0; delay = 0; delivered = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      // Model the effect of the edge that just passed, given the inputs held before it.
      redir   = d_redir | d_trap;
      exp_mis = d_redir & ~d_trap & (d_tgt[1:0] != 2'b00);
      if (exp_valid && (d_ready || redir)) exp_valid = 1'b0;
      if (d_rvalid) begin
        if (!pend_sq && !redir) begin
          exp_valid    = 1'b1;
          exp_if_pc    = pend_addr;
          exp_if_instr = mem_word(pend_addr);
          exp_pc       = pend_addr + 32'd4;
          delivered++;
        end
        pend = 1'b0;
      end else if (pend && redir) begin
        pend_sq = 1'b1;
      end
      if (d_gnt) begin
        pend      = 1'b1;
        pend_sq   = redir;
        pend_addr = exp_pc;
        delay     = int'($urandom_range(0, 2));
      end
      if (redir) exp_pc = d_trap ? DEFAULT_TRAP_VECTOR : {d_tgt[31:2], 2'b00};
      idle    = 1'b0;
      exp_req = !idle && !pend && !exp_valid;

      checkOutput("rnd_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) checkOutput("rnd_addr", imem_addr, exp_pc);
      checkOutput("rnd_pc_out", pc_out, exp_pc);
      checkOutput("rnd_if_valid", 32'(if_valid), 32'(exp_valid));
      if (exp_valid) begin
        checkOutput("rnd_if_pc", if_pc, exp_if_pc);
        checkOutput("rnd_if_instr", if_instr, exp_if_instr);
      end
      checkOutput("rnd_misalign", 32'(misalign_err), 32'(exp_mis));

      d_rvalid = 1'b0;
      if (pend) begin
        if (delay == 0) d_rvalid = 1'b1;
        else delay--;
      end
      d_gnt   = exp_req && ($urandom_range(0, 3) != 0);
      r32     = $urandom;
      d_trap  = (r32[3:0] == 4'd0);
      d_redir = (r32[3:0] < 4'd3);
      d_ready = (r32[5:4] != 2'b00);
      case (r32[7:6])
        2'd0:    d_tgt = {16'h8000, r32[23:8]};
        2'd1:    d_tgt = {30'h3FFF_FFFF, r32[9:8]};
        2'd2:    d_tgt = $urandom;
        default: d_tgt = {24'h800000, r32[15:8]};
      endcase
      redirect_valid  = d_redir;
      redirect_target = d_tgt;
      trap_valid      = d_trap;
      imem_gnt        = d_gnt;
      imem_rvalid     = d_rvalid;
      imem_rdata      = d_rvalid ? mem_word(pend_addr) : $urandom;
      if_ready        = d_ready;
    end
    checkOutput("rnd_progress", 32'(delivered > 20), 32'd1);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 rst = 1'b0;
    #1 checkReset("reset");

    // Zero-wait fetches, a stalled HOLD, squashes, trap priority, misalign and PC wrap.
    tbl.push_back(mk(0, 32'h0, 0, 0, 0, 32'h0,         0, 1, 32'h8000_0000, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(0, 32'h0, 0, 1, 0, 32'h0,         0, 0, 32'h8000_0000, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(0, 32'h0, 0, 0, 1, 32'h1111_1111, 0, 0, 32'h8000_0004, 1, 32'h8000_0000, 32'h1111_1111, 0));
    tbl.push_back(mk(0, 32'h0, 0, 0, 0, 32'h0,         1, 1, 32'h8000_0004, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(0, 32'h0, 0, 1, 0, 32'h0,         0, 0, 32'h8000_0004, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(0, 32'h0, 0, 0, 1, 32'h2222_2222, 0, 0, 32'h8000_0008, 1, 32'h8000_0004, 32'h2222_2222, 0));
    tbl.push_back(mk(0, 32'h0, 0, 0, 0, 32'h0,         1, 1, 32'h8000_0008, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(0, 32'h0, 0, 1, 0, 32'h0,         0, 0, 32'h8000_0008, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(0, 32'h0, 0, 0, 1, 32'hCAFE_BABE, 0, 0, 32'h8000_000C, 1, 32'h8000_0008, 32'hCAFE_BABE, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 32'h0, 0, 0, 0, 32'h0,       0, 0, 32'h8000_000C, 1, 32'h8000_0008, 32'hCAFE_BABE, 0));
    tbl.push_back(mk(0, 32'h0, 0, 0, 0, 32'h0,         1, 1, 32'h8000_000C, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(0, 32'h0, 0, 1, 0, 32'h0,         0, 0, 32'h8000_000C, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(1, 32'h8000_0100, 0, 0, 0, 32'h0, 0, 0, 32'h8000_0100, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(0, 32'h0, 0, 0, 1, 32'hDEAD_BEEF, 0, 1, 32'h8000_0100, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(1, 32'h8000_0200, 1, 0, 0, 32'h0, 0, 1, 32'h8000_0004, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(1, 32'h8000_0102, 0, 0, 0, 32'h0, 0, 1, 32'h8000_0100, 0, 32'h0,         32'h0,         1));
    tbl.push_back(mk(0, 32'h0, 0, 0, 0, 32'h0,         0, 1, 32'h8000_0100, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(1, 32'hFFFF_FFFC, 0, 1, 0, 32'h0, 0, 0, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(0, 32'h0, 0, 0, 1, 32'h0BAD_F00D, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(0, 32'h0, 0, 1, 0, 32'h0,         0, 0, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(0, 32'h0, 0, 0, 1, 32'h1357_9BDF, 0, 0, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h1357_9BDF, 0));
    tbl.push_back(mk(0, 32'h0, 0, 0, 0, 32'h0,         1, 1, 32'h0000_0000, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(0, 32'h0, 0, 1, 0, 32'h0,         0, 0, 32'h0000_0000, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(1, 32'h8000_0040, 0, 0, 1, 32'h5555_5555, 0, 1, 32'h8000_0040, 0, 32'h0, 32'h0,       0));
    tbl.push_back(mk(0, 32'h0, 0, 1, 0, 32'h0,         0, 0, 32'h8000_0040, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(0, 32'h0, 0, 0, 1, 32'h6666_6666, 0, 0, 32'h8000_0044, 1, 32'h8000_0040, 32'h6666_6666, 0));
    tbl.push_back(mk(1, 32'h8000_0080, 0, 0, 0, 32'h0, 0, 1, 32'h8000_0080, 0, 32'h0,         32'h0,         0));

    repeat (2) @(negedge clk);
    rst = 1'b1;
    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_req", i), 32'(imem_req), 32'(tbl[i].e_req));
      if (tbl[i].e_req) checkOutput($sformatf("vec%0d_addr", i), imem_addr, tbl[i].e_pc);
      checkOutput($sformatf("vec%0d_pc_out", i), pc_out, tbl[i].e_pc);
      checkOutput($sformatf("vec%0d_if_valid", i), 32'(if_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        checkOutput($sformatf("vec%0d_if_pc", i), if_pc, tbl[i].e_if_pc);
        checkOutput($sformatf("vec%0d_if_instr", i), if_instr, tbl[i].e_instr);
      end
      checkOutput($sformatf("vec%0d_misalign", i), 32'(misalign_err), 32'(tbl[i].e_mis));
    end

    // Asynchronous reset while a fetch is outstanding, then the first request afterwards.
    applyStimulus(mk(0, 32'h0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 checkOutput("hw_wait_req", 32'(imem_req), 32'd0);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 rst = 1'b0;
    #1 checkReset("hw_midwait_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 checkOutput("hw_idle_req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("hw_first_req", 32'(imem_req), 32'd1);
    checkOutput("hw_first_addr", imem_addr, 32'h8000_0000);

    runRandom(4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
